// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: word size, register-number width and
// the architecturally special register numbers.
package reg_file_pkg;
    localparam int WORD_SIZE = 32;
    localparam int REG_NUM_W = 5;

    typedef logic [REG_NUM_W-1:0] reg_num_t;

    localparam reg_num_t REG_ZERO = 5'd0;
    // Link register; the write-back select stage also picks this for jal.
    localparam reg_num_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file_bypass.sv
// One read port: selects the in-flight write-back value over stored state
// when the destination matches, except while reset is asserted.
module reg_file_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_num,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_num,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);
    logic hit;

    assign hit       = !rst && reg_write && (write_num != '0) && (write_num == read_num);
    assign read_data = hit ? write_data : stored_data;
endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS GPR file: two bypassed combinational read ports, one write
// port, committed-write counter. Define REG_FILE_DEBUG_EN for the debug port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = WORD_SIZE,
    parameter int ADDR_W = REG_NUM_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_num,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rs_num,
    input  logic [ADDR_W-1:0] rt_num,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
`ifdef REG_FILE_DEBUG_EN
    input  logic [ADDR_W-1:0] dbg_num,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] last_write,
`endif
    output logic [CNT_W-1:0]  wr_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PORTS = 2;

    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic [PORTS-1:0][ADDR_W-1:0]  rd_num;
    logic [PORTS-1:0][DATA_W-1:0]  rd_stored;
    logic [PORTS-1:0][DATA_W-1:0]  rd_data;
    logic                          commit;

    assign commit = reg_write && (write_num != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            wr_count <= '0;
`ifdef REG_FILE_DEBUG_EN
            last_write <= '0;
`endif
        end else if (commit) begin
            mem[write_num] <= write_data;
            wr_count       <= wr_count + CNT_W'(1);
`ifdef REG_FILE_DEBUG_EN
            last_write     <= write_num;
`endif
        end
    end

    assign rd_num = {rt_num, rs_num};

    genvar p;
    generate
        for (p = 0; p < PORTS; p++) begin : g_port
            // $0 reads as zero even before the first reset clears storage.
            assign rd_stored[p] = (rd_num[p] == '0) ? '0 : mem[rd_num[p]];

            reg_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp (
                .rst        (rst),
                .read_num   (rd_num[p]),
                .stored_data(rd_stored[p]),
                .reg_write  (reg_write),
                .write_num  (write_num),
                .write_data (write_data),
                .read_data  (rd_data[p])
            );
        end
    endgenerate

    assign rs_data = rd_data[0];
    assign rt_data = rd_data[1];

`ifdef REG_FILE_DEBUG_EN
    assign dbg_data = (dbg_num == '0) ? '0 : mem[dbg_num];
`endif
endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file against an array-based model;
// a narrow-counter instance exercises counter wrap.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst, reg_write;
    logic [4:0]  write_num, rs_num, rt_num;
    logic [31:0] write_data;
    logic [31:0] rs_data, rt_data, rs_data2, rt_data2;
    logic [31:0] wr_count;
    logic [3:0]  wr_count2;
`ifdef REG_FILE_DEBUG_EN
    logic [4:0]  dbg_num, last_write, last_write2;
    logic [31:0] dbg_data, dbg_data2;
`endif

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_num(write_num),
        .write_data(write_data), .rs_num(rs_num), .rt_num(rt_num),
        .rs_data(rs_data), .rt_data(rt_data),
`ifdef REG_FILE_DEBUG_EN
        .dbg_num(dbg_num), .dbg_data(dbg_data), .last_write(last_write),
`endif
        .wr_count(wr_count)
    );

    reg_file #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_num(write_num),
        .write_data(write_data), .rs_num(rs_num), .rt_num(rt_num),
        .rs_data(rs_data2), .rt_data(rt_data2),
`ifdef REG_FILE_DEBUG_EN
        .dbg_num(dbg_num), .dbg_data(dbg_data2), .last_write(last_write2),
`endif
        .wr_count(wr_count2)
    );

    typedef struct {
        logic [31:0] rs, rt, cnt, dbg;
        logic [3:0]  cnt2;
        logic [4:0]  lw;
    } exp_t;

    exp_t        sb[$];
    event        chk;
    int          total = 0;
    int          bad   = 0;

    // Reference model: architectural state as plain arrays and integers.
    logic [31:0] m_reg [32];
    int unsigned m_cnt;
    logic [4:0]  m_last;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e = sb.pop_front();
                cmp("rs_data",   rs_data,   e.rs);
                cmp("rt_data",   rt_data,   e.rt);
                cmp("wr_count",  wr_count,  e.cnt);
                cmp("rs_data2",  rs_data2,  e.rs);
                cmp("wr_count4", {28'd0, wr_count2}, {28'd0, e.cnt2});
`ifdef REG_FILE_DEBUG_EN
                cmp("dbg_data",   dbg_data,   e.dbg);
                cmp("last_write", {27'd0, last_write}, {27'd0, e.lw});
`endif
            end
        end
    end

    // One clock of stimulus: drive mid-cycle, predict pre-edge outputs, then commit the model.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wn,
                         input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic check);
        exp_t e;
        logic byp;
        logic [4:0] dn;
        @(negedge clk);
        dn = 5'($urandom_range(0, 31));
        rst = r; reg_write = we; write_num = wn; write_data = wd; rs_num = rs; rt_num = rt;
`ifdef REG_FILE_DEBUG_EN
        dbg_num = dn;
`endif
        byp    = !r && we && (wn != 5'd0);
        e.rs   = (byp && wn == rs) ? wd : m_reg[rs];
        e.rt   = (byp && wn == rt) ? wd : m_reg[rt];
        e.dbg  = m_reg[dn];
        e.cnt  = m_cnt;
        e.cnt2 = 4'(m_cnt % 16);
        e.lw   = m_last;
        if (check) begin
            sb.push_back(e);
            ->chk;
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_cnt = 0; m_last = '0;
        end else if (byp) begin
            m_reg[wn] = wd; m_cnt++; m_last = wn;
        end
    endtask

    initial begin
        logic [4:0] wn;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_cnt = 0; m_last = '0;
        rst = 1'b1; reg_write = 1'b0; write_num = '0; write_data = '0; rs_num = '0; rt_num = '0;
`ifdef REG_FILE_DEBUG_EN
        dbg_num = '0;
`endif
        // Storage is undefined before the first reset, so that cycle is not predicted.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 1);

        cycle(0, 1, 8, 32'hDEADBEEF, 8, 0, 1);
        cycle(0, 0, 0, 0, 8, 8, 1);
        cycle(0, 1, 31, 32'h00000041, 31, 31, 1);
        cycle(0, 0, 0, 0, 31, 8, 1);
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 5, 32'h12345678, 5, 5, 1);
        cycle(0, 0, 0, 0, 5, 8, 1);

        // Fill the narrow counter to all-ones, then write $3 across the wrap.
        for (int i = 0; i < 15; i++) cycle(0, 1, 5'(1 + i % 30), $urandom, 0, 0, 1);
        cycle(0, 0, 0, 0, 3, 3, 1);
        cycle(0, 1, 3, 32'hC0FFEE03, 3, 1, 1);
        cycle(0, 0, 0, 0, 3, 3, 1);

        for (int i = 0; i < 600; i++) begin
            wn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, wn, $urandom,
                  ($urandom_range(0, 2) == 0) ? wn : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? wn : 5'($urandom), 1);
        end

        @(negedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural 32-entry MIPS general-purpose register file.
- Directly downstream of the write-back select stage: consumes its destination register number and write data, and commits them on the clock edge.
- Provides two combinational read ports to decode, with same-cycle write-to-read bypass.
- Keeps a committed-write counter for performance and debug visibility.

Parameters:
- DATA_W, `WORD_SIZE (32), width of each register and of the read/write data.
- ADDR_W, 5, register-number width; depth is 2**ADDR_W = 32.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  write-back enable for the instruction currently in WB.
- write_num  input  ADDR_W  destination register number from the write-back select stage.
- write_data  input  DATA_W  write-back data from the write-back select stage.
- rs_num  input  ADDR_W  read port A register number.
- rt_num  input  ADDR_W  read port B register number.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- wr_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset: when rst=1 at a rising edge, all 32 registers become 0 and wr_count becomes 0. rst has priority over any write in that same cycle; the write is dropped and is not counted.
- After reset, read ports return 0 for every register until that register is written.
- Commit: at a rising edge with rst=0, reg_write=1 and write_num!=0, reg[write_num] <= write_data and wr_count <= wr_count+1.
- Register $0: hardwired to zero. A write to $0 is discarded, is not counted, and never appears on the bypass.
- Reads: rs_data and rt_data are combinational from rs_num and rt_num. Zero latency.
- Bypass: if reg_write=1, write_num!=0 and write_num==rs_num, then rs_data=write_data in the same cycle, before the edge. Port B has the identical rule against rt_num.
- Bypass on both ports: when rs_num==rt_num==write_num, both ports show the bypassed value.
- Bypass during reset: while rst=1, bypass is suppressed and reads reflect stored contents.
- wr_count: CNT_W-bit unsigned counter. Wraps from all-ones to 0 with no flag.
- Write timing: at most one write per cycle; the write is visible in stored state from the cycle after the edge.
- Undefined inputs: X on write_num while reg_write=0 has no effect.

Optional Feature:
- Macro: REG_FILE_DEBUG_EN.
- With the macro defined:
  - Adds input dbg_num [ADDR_W] and output dbg_data [DATA_W].
  - dbg_data is a combinational third read port, with no bypass. It feeds the board display.
  - Adds output last_write [ADDR_W], which is the register number of the most recent committed write. It resets to 0 and updates only on counted writes.
- Without the macro: these ports and their logic do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package/header (definitions.vh) holds:
  - WORD_SIZE;
  - REG_NUM_W = 5;
  - REG_ZERO = 5'd0 and REG_RA = 5'd31, where REG_RA is shared with the write-back select stage's link-register choice;
  - a reg_num_t typedef.
- Sub-module: reg_file_bypass, one instance per read port. Inputs: read number, stored data, write enable, write number, write data, rst. Output: the selected data.
- Storage, the write logic and the counter stay in reg_file.

Test Plan:
- Reset behaviour: assert rst for 1 cycle, then read all rs_num 0..31 -> all 0, wr_count=0.
- Write, bypass and commit: reg_write=1, write_num=8, write_data=0xDEADBEEF with rs_num=8 in the same cycle -> rs_data=0xDEADBEEF before the edge. After the edge, with reg_write=0 -> rs_data=0xDEADBEEF and wr_count=1.
- Link-register write: reg_write=1, write_num=31, write_data=0x00000041 (a jal link value), with rs_num=rt_num=31 -> both ports 0x00000041. After the edge, wr_count increments.
- $0 protection: reg_write=1, write_num=0, write_data=0xFFFFFFFF, rs_num=0 -> rs_data=0 before and after the edge, wr_count unchanged.
- Reset priority: the write 0x12345678 to $5 coincides with rst=1 -> after the edge reg5=0 and wr_count=0. In the same cycle rs_num=5 -> rs_data=0, because the bypass is suppressed.
- Counter wrap: force wr_count=0xFFFFFFFF (CNT_W=32), then one valid write to $3 -> wr_count=0 and reg3 updated.
